// File: rtl/csa_pipe_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : csa_pipe_addsub
// Brief    : Two-stage pipelined carry-select adder/subtractor with flags and
//            a valid/ready handshake (2 beats of buffering).
// Revision : 1.0 - initial release
// ============================================================================
module csa_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSEG = WIDTH / SEG_W;

    generate
        if (((WIDTH % SEG_W) != 0) || (NSEG < 2)) begin : g_bad_cfg
            $error("csa_pipe_addsub: WIDTH must be a multiple of SEG_W and WIDTH/SEG_W must be >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s2_free;
    logic w_s1_adv;
    logic w_in_fire;

    assign w_s2_free = !r_out_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_in_fire = in_valid && in_ready;

    // ------------------------------------------------------------------------
    // Stage 1: segment 0 with the real carry-in, upper segments speculatively
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]               w_bx;
    logic                           w_cx;
    logic [SEG_W:0]                 w_lo;
    logic [NSEG-1:1][SEG_W-1:0]     w_p0;
    logic [NSEG-1:1][SEG_W-1:0]     w_p1;
    logic [NSEG-1:1]                w_c0;
    logic [NSEG-1:1]                w_c1;

    assign w_bx = op ? ~b : b;
    assign w_cx = op | cin;
    assign w_lo = {1'b0, a[SEG_W-1:0]} + {1'b0, w_bx[SEG_W-1:0]} + {{SEG_W{1'b0}}, w_cx};

    generate
        for (genvar k = 1; k < NSEG; k++) begin : g_seg
            logic [SEG_W:0] w_t0;
            logic [SEG_W:0] w_t1;

            assign w_t0 = {1'b0, a[k*SEG_W +: SEG_W]} + {1'b0, w_bx[k*SEG_W +: SEG_W]};
            assign w_t1 = {1'b0, a[k*SEG_W +: SEG_W]} + {1'b0, w_bx[k*SEG_W +: SEG_W]}
                        + {{SEG_W{1'b0}}, 1'b1};
            assign w_p0[k] = w_t0[SEG_W-1:0];
            assign w_c0[k] = w_t0[SEG_W];
            assign w_p1[k] = w_t1[SEG_W-1:0];
            assign w_c1[k] = w_t1[SEG_W];
        end
    endgenerate

    logic [SEG_W-1:0]               r_s1_p_lo;
    logic                           r_s1_c_lo;
    logic [NSEG-1:1][SEG_W-1:0]     r_s1_p0;
    logic [NSEG-1:1][SEG_W-1:0]     r_s1_p1;
    logic [NSEG-1:1]                r_s1_c0;
    logic [NSEG-1:1]                r_s1_c1;
    logic                           r_s1_a_msb;
    logic                           r_s1_bx_msb;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_p_lo   <= '0;
            r_s1_c_lo   <= 1'b0;
            r_s1_p0     <= '0;
            r_s1_p1     <= '0;
            r_s1_c0     <= '0;
            r_s1_c1     <= '0;
            r_s1_a_msb  <= 1'b0;
            r_s1_bx_msb <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_in_fire) begin
                r_s1_p_lo   <= w_lo[SEG_W-1:0];
                r_s1_c_lo   <= w_lo[SEG_W];
                r_s1_p0     <= w_p0;
                r_s1_p1     <= w_p1;
                r_s1_c0     <= w_c0;
                r_s1_c1     <= w_c1;
                r_s1_a_msb  <= a[WIDTH-1];
                r_s1_bx_msb <= w_bx[WIDTH-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: resolve segment carries through the mux chain, select sums
    // ------------------------------------------------------------------------
    logic [NSEG-1:0]  w_carry;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_ovf_nxt;
    logic             w_zero_nxt;

    always_comb begin
        w_carry   = '0;
        w_sum_nxt = '0;
        w_carry[0]             = r_s1_c_lo;
        w_sum_nxt[SEG_W-1:0]   = r_s1_p_lo;
        for (int k = 1; k < NSEG; k++) begin
            w_sum_nxt[k*SEG_W +: SEG_W] = w_carry[k-1] ? r_s1_p1[k] : r_s1_p0[k];
            w_carry[k]                  = w_carry[k-1] ? r_s1_c1[k] : r_s1_c0[k];
        end
    end

    assign w_ovf_nxt  = (r_s1_a_msb == r_s1_bx_msb) && (w_sum_nxt[WIDTH-1] != r_s1_a_msb);
    assign w_zero_nxt = ~|w_sum_nxt;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    // Output register only reloads when free, so a stalled result stays put.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_s2_free) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= w_sum_nxt;
                r_cout <= w_carry[NSEG-1];
                r_ovf  <= w_ovf_nxt;
                r_zero <= w_zero_nxt;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_csa_pipe_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_csa_pipe_addsub
// Brief    : Self-checking bench: directed vector table, backpressure and
//            reset sequences, random regression at 32/8 and 16/4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_pipe_addsub;

    localparam int RAND_N     = 10000;
    localparam int RAND_BOUND = 40000;

    typedef struct packed {
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        op;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] a = '0, b = '0, sum;
    logic        cin = 1'b0, op = 1'b0, cout, ovf, zero;

    logic        h_in_valid = 1'b0, h_in_ready, h_out_valid, h_out_ready = 1'b0;
    logic [15:0] h_a = '0, h_b = '0, h_sum;
    logic        h_cin = 1'b0, h_op = 1'b0, h_cout, h_ovf, h_zero;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    csa_pipe_addsub #(.WIDTH(32), .SEG_W(8)) dut32 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    csa_pipe_addsub #(.WIDTH(16), .SEG_W(4)) dut16 (
        .clock(clock), .reset(reset),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .cin(h_cin), .op(h_op),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .sum(h_sum), .cout(h_cout), .ovf(h_ovf), .zero(h_zero)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, signed range test for ovf.
    function automatic res_t ref_model(input int w, input logic [63:0] av_in, input logic [63:0] bv_in,
                                       input logic ci, input logic o);
        res_t        r;
        logic [63:0] mask;
        logic [63:0] av, bv;
        longint      full, sa, sb, sr, lim;
        mask = (64'd1 << w) - 64'd1;
        av   = av_in & mask;
        bv   = bv_in & mask;
        if (!o) begin
            full = longint'(av) + longint'(bv) + longint'(ci);
            r.co = ((full >> w) & 1) != 0;
        end else begin
            full = longint'(av) - longint'(bv);
            r.co = (av >= bv);
        end
        r.s  = 64'(full) & mask;
        lim  = longint'(1) <<< (w - 1);
        sa   = av[w-1] ? longint'(av) - (lim * 2) : longint'(av);
        sb   = bv[w-1] ? longint'(bv) - (lim * 2) : longint'(bv);
        sr   = o ? (sa - sb) : (sa + sb + longint'(ci));
        r.ov = (sr > lim - 1) || (sr < -lim);
        r.z  = (r.s == 64'd0);
        return r;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return mask;
            2:       return 64'd1 << (w - 1);
            3:       return (64'd1 << (w - 1)) - 64'd1;
            default: return {32'd0, $urandom} & mask;
        endcase
    endfunction

    function automatic res_t cur32();
        res_t r;
        r.s  = 64'(sum);
        r.co = cout;
        r.ov = ovf;
        r.z  = zero;
        return r;
    endfunction

    function automatic res_t cur16();
        res_t r;
        r.s  = 64'(h_sum);
        r.co = h_cout;
        r.ov = h_ovf;
        r.z  = h_zero;
        return r;
    endfunction

    // One beat into an idle pipe: checks acceptance, latency of two cycles, result.
    task automatic apply_vec(input vec_t v, input string nm);
        @(negedge clock);
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        cin       = v.cin;
        op        = v.op;
        out_ready = 1'b1;
        #1 chk({nm, "_in_ready"}, in_ready, 1'b1);
        @(negedge clock);
        in_valid = 1'b0;
        #1 chk({nm, "_early_valid"}, out_valid, 1'b0);
        @(negedge clock);
        #1 chk({nm, "_lat2_valid"}, out_valid, 1'b1);
        chk({nm, "_result"}, {sum, cout, ovf, zero}, {v.s, v.co, v.ov, v.z});
    endtask

    task automatic drive_beat(input logic [31:0] av, input logic [31:0] bv, input logic o);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        op       = o;
        cin      = 1'b0;
    endtask

    task automatic run_random(input int n);
        res_t qa[$];
        res_t qb[$];
        res_t ca, cb, last_a, last_b;
        int   acc_a = 0, acc_b = 0, out_a = 0, out_b = 0, cyc = 0;
        bit   hold_a = 1'b0, hold_b = 1'b0;
        last_a = '0;
        last_b = '0;
        while ((acc_a < n || acc_b < n || qa.size() != 0 || qb.size() != 0) && cyc < RAND_BOUND) begin
            @(negedge clock);
            in_valid    = (acc_a < n) && ($urandom_range(0, 3) != 0);
            a           = 32'(pick(32));
            b           = 32'(pick(32));
            cin         = 1'($urandom_range(0, 1));
            op          = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            h_in_valid  = (acc_b < n) && ($urandom_range(0, 3) != 0);
            h_a         = 16'(pick(16));
            h_b         = 16'(pick(16));
            h_cin       = 1'($urandom_range(0, 1));
            h_op        = 1'($urandom_range(0, 1));
            h_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            ca = cur32();
            cb = cur16();
            if (hold_a) chk("rand32_stall_stable", {out_valid, ca}, {1'b1, last_a});
            if (hold_b) chk("rand16_stall_stable", {h_out_valid, cb}, {1'b1, last_b});
            if (out_valid && out_ready) begin
                if (qa.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL rand32_extra_beat: got result %0h expected no beat", ca);
                end else begin
                    chk("rand32_result", ca, qa.pop_front());
                end
                out_a++;
            end
            if (h_out_valid && h_out_ready) begin
                if (qb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL rand16_extra_beat: got result %0h expected no beat", cb);
                end else begin
                    chk("rand16_result", cb, qb.pop_front());
                end
                out_b++;
            end
            hold_a = out_valid && !out_ready;
            hold_b = h_out_valid && !h_out_ready;
            last_a = ca;
            last_b = cb;
            if (in_valid && in_ready) begin
                qa.push_back(ref_model(32, 64'(a), 64'(b), cin, op));
                acc_a++;
            end
            if (h_in_valid && h_in_ready) begin
                qb.push_back(ref_model(16, 64'(h_a), 64'(h_b), h_cin, h_op));
                acc_b++;
            end
            cyc++;
        end
        chk("rand_within_bound", (cyc < RAND_BOUND), 1'b1);
        chk("rand32_count", out_a, acc_a);
        chk("rand16_count", out_b, acc_b);
        chk("rand32_accepted", acc_a, n);
        chk("rand16_accepted", acc_b, n);
        in_valid   = 1'b0;
        h_in_valid = 1'b0;
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_outputs", {sum, cout, ovf, zero}, 35'd0);
        chk("reset16_out_valid", h_out_valid, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("post_reset_in_ready", in_ready, 1'b1);
        chk("post_reset16_in_ready", h_in_ready, 1'b1);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: three beats against a stalled output
        @(negedge clock);
        out_ready = 1'b0;
        drive_beat(32'd1, 32'd2, 1'b0);
        #1 chk("bp_ready0", in_ready, 1'b1);
        @(negedge clock);
        drive_beat(32'd10, 32'd3, 1'b1);
        #1 chk("bp_ready1", in_ready, 1'b1);
        @(negedge clock);
        drive_beat(32'hFFFF_FFFF, 32'd1, 1'b0);
        #1 chk("bp_ready2_blocked", in_ready, 1'b0);
        chk("bp_hold_a", {out_valid, sum}, {1'b1, 32'd3});
        @(negedge clock);
        #1 chk("bp_ready3_blocked", in_ready, 1'b0);
        chk("bp_hold_b", {out_valid, sum}, {1'b1, 32'd3});
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1'b1);
        chk("bp_out0", {out_valid, sum, cout}, {1'b1, 32'd3, 1'b0});
        @(negedge clock);
        in_valid = 1'b0;
        #1 chk("bp_out1", {out_valid, sum, cout}, {1'b1, 32'd7, 1'b1});
        @(negedge clock);
        #1 chk("bp_out2", {out_valid, sum, cout, zero}, {1'b1, 32'd0, 1'b1, 1'b1});
        @(negedge clock);
        #1 chk("bp_drained", out_valid, 1'b0);

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0;
        drive_beat(32'h0000_1111, 32'h0000_2222, 1'b0);
        @(negedge clock);
        drive_beat(32'h0000_3333, 32'h0000_0001, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        #1 chk("rst_pre_valid", {out_valid, sum}, {1'b1, 32'h0000_3333});
        #1 reset = 1'b1;
        #1 chk("rst_async_valid", out_valid, 1'b0);
        chk("rst_async_sum", sum, 32'd0);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1 chk($sformatf("rst_no_stale%0d", i), out_valid, 1'b0);
        end
        apply_vec(vecs[2], "post_rst_vec");

        // Random regression on both configurations
        run_random(RAND_N);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
